// File: rtl/bht_restore_pkg.sv
// Shared types and constants for the BHT checkpoint restore path.
// The checkpoint entry format is common to the checkpoint writer and reader.
package bht_restore_pkg;

  localparam int unsigned INSTR_PER_FETCH           = 2;
  localparam int unsigned DCACHE_INDEX_WIDTH        = 12;
  localparam int unsigned DCACHE_TAG_WIDTH          = 44;
  localparam int unsigned BHT_CKPT_ENTRY_BITS       = 3;
  localparam int unsigned BHT_CKPT_ENTRIES_PER_WORD = 21;

  typedef struct packed {
    logic       valid;
    logic [1:0] saturation_counter;
  } bht_ckpt_entry_t;

  // Load-port request toward the D$
  typedef struct packed {
    logic [DCACHE_INDEX_WIDTH-1:0] address_index;
    logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
    logic [63:0]                   data_wdata;
    logic                          data_req;
    logic                          data_we;
    logic [7:0]                    data_be;
    logic [1:0]                    data_size;
    logic                          kill_req;
    logic                          tag_valid;
  } dcache_req_i_t;

  // Load-port response from the D$
  typedef struct packed {
    logic        data_gnt;
    logic        data_rvalid;
    logic [63:0] data_rdata;
  } dcache_req_o_t;

endpackage

// File: rtl/bht_restore.sv
// Restores the BHT from a memory checkpoint: loads packed 64-bit words
// through a D$ load port and replays one 3-bit entry per cycle into the BHT.
module bht_restore
  import bht_restore_pkg::*;
#(
  parameter int unsigned NR_ENTRIES       = 1024,
  parameter int unsigned ENTRIES_PER_WORD = BHT_CKPT_ENTRIES_PER_WORD
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   start_i,
  input  logic                                   abort_i,
  input  logic [63:0]                            restore_addr_i,
  output dcache_req_i_t                          dcache_req_o,
  input  dcache_req_o_t                          dcache_rsp_i,
  output logic                                   bht_wr_valid_o,
  output logic [$clog2(NR_ENTRIES/INSTR_PER_FETCH)-1:0] bht_wr_row_o,
  output logic [(INSTR_PER_FETCH > 1 ? $clog2(INSTR_PER_FETCH) : 1)-1:0] bht_wr_col_o,
  output bht_ckpt_entry_t                        bht_wr_entry_o,
  output logic                                   busy_o,
  output logic                                   done_o
);

  localparam int unsigned NR_WORDS = (NR_ENTRIES + ENTRIES_PER_WORD - 1) / ENTRIES_PER_WORD;
  localparam int unsigned WORD_W   = (NR_WORDS > 1) ? $clog2(NR_WORDS) : 1;
  localparam int unsigned SLOT_W   = (ENTRIES_PER_WORD > 1) ? $clog2(ENTRIES_PER_WORD) : 1;
  localparam int unsigned ENTRY_W  = $clog2(NR_ENTRIES);
  localparam int unsigned ROW_W    = $clog2(NR_ENTRIES / INSTR_PER_FETCH);
  localparam int unsigned COL_W    = (INSTR_PER_FETCH > 1) ? $clog2(INSTR_PER_FETCH) : 1;
  localparam int unsigned ADDR_W   = DCACHE_INDEX_WIDTH + DCACHE_TAG_WIDTH;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] REQ    = 3'd1;
  localparam logic [2:0] TAG    = 3'd2;
  localparam logic [2:0] WAIT   = 3'd3;
  localparam logic [2:0] UNPACK = 3'd4;
  localparam logic [2:0] DRAIN  = 3'd5;
  localparam logic [2:0] DONE   = 3'd6;

  logic [2:0]         state_q, state_d;
  logic [63:0]        base_q, base_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic [SLOT_W-1:0]  slot_q, slot_d;
  logic [ENTRY_W-1:0] entry_q, entry_d;
  logic [63:0]        data_q, data_d;
  logic               kill_q, kill_d;
  logic [63:0]        word_addr;
  logic               unused_bits;

  function automatic bht_ckpt_entry_t slot_entry(input logic [63:0] word,
                                                 input logic [SLOT_W-1:0] slot);
    return word[BHT_CKPT_ENTRY_BITS*slot +: BHT_CKPT_ENTRY_BITS];
  endfunction

  assign word_addr   = base_q + {{(64-WORD_W-3){1'b0}}, word_q, 3'b000};
  assign unused_bits = ^{word_addr[63:ADDR_W], data_q[63]};
  assign busy_o      = (state_q != IDLE);

  // Next-state, counter updates and all port outputs
  always_comb begin
    state_d        = state_q;
    base_d         = base_q;
    word_d         = word_q;
    slot_d         = slot_q;
    entry_d        = entry_q;
    data_d         = data_q;
    kill_d         = kill_q;
    dcache_req_o   = '0;
    bht_wr_valid_o = 1'b0;
    bht_wr_row_o   = '0;
    bht_wr_col_o   = '0;
    bht_wr_entry_o = '0;
    done_o         = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          base_d  = restore_addr_i;
          word_d  = '0;
          slot_d  = '0;
          entry_d = '0;
          kill_d  = 1'b0;
          state_d = REQ;
        end
      end
      REQ: begin
        dcache_req_o.data_be       = 8'hFF;
        dcache_req_o.data_size     = 2'b11;
        dcache_req_o.address_index = word_addr[DCACHE_INDEX_WIDTH-1:0];
        // An abort only withdraws the request if it has not been granted;
        // a granted load must still see its tag phase so it can be killed.
        dcache_req_o.data_req      = !(abort_i && !dcache_rsp_i.data_gnt);
        if (dcache_rsp_i.data_gnt) begin
          kill_d  = abort_i;
          state_d = TAG;
        end else if (abort_i) begin
          state_d = IDLE;
        end
      end
      TAG: begin
        dcache_req_o.data_be       = 8'hFF;
        dcache_req_o.data_size     = 2'b11;
        dcache_req_o.address_index = word_addr[DCACHE_INDEX_WIDTH-1:0];
        dcache_req_o.address_tag   = word_addr[ADDR_W-1:DCACHE_INDEX_WIDTH];
        dcache_req_o.tag_valid     = 1'b1;
        dcache_req_o.kill_req      = kill_q || abort_i;
        kill_d  = 1'b0;
        state_d = (kill_q || abort_i) ? IDLE : WAIT;
      end
      WAIT: begin
        if (abort_i) begin
          state_d = dcache_rsp_i.data_rvalid ? IDLE : DRAIN;
        end else if (dcache_rsp_i.data_rvalid) begin
          data_d  = dcache_rsp_i.data_rdata;
          slot_d  = '0;
          state_d = UNPACK;
        end
      end
      UNPACK: begin
        if (abort_i) begin
          state_d = IDLE;
        end else begin
          bht_wr_valid_o = 1'b1;
          bht_wr_row_o   = ROW_W'(entry_q / INSTR_PER_FETCH);
          bht_wr_col_o   = COL_W'(entry_q % INSTR_PER_FETCH);
          bht_wr_entry_o = slot_entry(data_q, slot_q);
          entry_d        = entry_q + ENTRY_W'(1);
          slot_d         = slot_q + SLOT_W'(1);
          if (entry_q == ENTRY_W'(NR_ENTRIES - 1)) begin
            state_d = DONE;
          end else if (slot_q == SLOT_W'(ENTRIES_PER_WORD - 1)) begin
            word_d  = word_q + WORD_W'(1);
            state_d = REQ;
          end
        end
      end
      DRAIN: begin
        if (dcache_rsp_i.data_rvalid) state_d = IDLE;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      base_q  <= '0;
      word_q  <= '0;
      slot_q  <= '0;
      entry_q <= '0;
      data_q  <= '0;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      word_q  <= word_d;
      slot_q  <= slot_d;
      entry_q <= entry_d;
      data_q  <= data_d;
      kill_q  <= kill_d;
    end
  end

endmodule

// File: tb/tb_bht_restore.sv
// Scoreboard bench for bht_restore: a D$ responder model serves loads,
// expected BHT writes are queued at stimulus time and popped by a monitor.
module tb_bht_restore;
  import bht_restore_pkg::*;

  localparam int NR_ENTRIES = 1024;
  localparam int EPW        = 21;
  localparam int NR_WORDS   = 49;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic            abort;
  logic [63:0]     restore_addr;
  dcache_req_i_t   dcache_req;
  dcache_req_o_t   dcache_rsp;
  logic            bht_wr_valid;
  logic [8:0]      bht_wr_row;
  logic [0:0]      bht_wr_col;
  bht_ckpt_entry_t bht_wr_entry;
  logic            busy;
  logic            done;

  bht_restore #(.NR_ENTRIES(NR_ENTRIES), .ENTRIES_PER_WORD(EPW)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .start_i        (start),
    .abort_i        (abort),
    .restore_addr_i (restore_addr),
    .dcache_req_o   (dcache_req),
    .dcache_rsp_i   (dcache_rsp),
    .bht_wr_valid_o (bht_wr_valid),
    .bht_wr_row_o   (bht_wr_row),
    .bht_wr_col_o   (bht_wr_col),
    .bht_wr_entry_o (bht_wr_entry),
    .busy_o         (busy),
    .done_o         (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [12:0] exp_q[$];   // {entry index, expected 3-bit entry}
  int wr_seen   = 0;
  int done_cnt  = 0;
  int grants    = 0;

  // Responder configuration / state
  logic [63:0] tb_base     = '0;
  int          mode        = 0;
  int          stall_word  = -1;
  int          stall_left  = 0;
  int          rv_delay    = 1;
  int          rv_cnt      = 0;
  int          req_num     = 0;
  logic        req_active  = 1'b0;
  logic [11:0] held_idx    = '0;
  logic [63:0] pending     = '0;
  logic        rv_fired    = 1'b0;
  logic [11:0] w1_index    = 12'hFFF;
  logic [43:0] w1_tag      = '1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] gen_word(input int w, input int m);
    logic [63:0] wd;
    int e;
    wd = '0;
    if (m == 1 && w == NR_WORDS - 1) return '1;
    for (int j = 0; j < EPW; j++) begin
      e = w * EPW + j;
      wd[3*j +: 3] = 3'(e % 8);
    end
    return wd;
  endfunction

  task automatic push_exp(input int first, input int count, input int m);
    int v;
    for (int e = first; e < first + count; e++) begin
      v = (m == 1 && e >= (NR_WORDS - 1) * EPW) ? 7 : e % 8;
      exp_q.push_back({10'(e), 3'(v)});
    end
  endtask

  task automatic set_run(input logic [63:0] base, input int m, input int sw, input int d);
    tb_base    = base;
    mode       = m;
    stall_word = sw;
    rv_delay   = d;
    req_num    = 0;
    stall_left = (sw == 0) ? 5 : 0;
    rv_cnt     = 0;
    req_active = 1'b0;
    rv_fired   = 1'b0;
    w1_index   = 12'hFFF;
    w1_tag     = '1;
    wr_seen    = 0;
    done_cnt   = 0;
    grants     = 0;
  endtask

  // D$ model: drives gnt/rvalid at +2, observes the request at +4
  always @(posedge clk) begin
    logic [63:0] a;
    #2;
    dcache_rsp.data_rvalid = 1'b0;
    dcache_rsp.data_gnt    = rst_n && (stall_left == 0);
    if (rv_cnt > 0) begin
      rv_cnt--;
      if (rv_cnt == 0) begin
        dcache_rsp.data_rvalid = 1'b1;
        dcache_rsp.data_rdata  = pending;
        rv_fired = 1'b1;
      end
    end
    #2;
    if (!rst_n) begin
      rv_cnt     = 0;
      req_active = 1'b0;
    end else begin
      if (dcache_req.tag_valid && !dcache_req.kill_req) begin
        a = tb_base + 64'(req_num - 1) * 64'd8;
        check("tag_address", 64'({dcache_req.address_tag, dcache_req.address_index}),
              {8'h00, a[55:0]});
        if (req_num == 2) w1_tag = dcache_req.address_tag;
        pending = gen_word(req_num - 1, mode);
        rv_cnt  = rv_delay;
      end
      if (dcache_req.data_req) begin
        if (!req_active) begin
          req_active = 1'b1;
          held_idx   = dcache_req.address_index;
          a = tb_base + 64'(req_num) * 64'd8;
          check("req_index", 64'(dcache_req.address_index), 64'(a[11:0]));
          if (req_num == 1) w1_index = dcache_req.address_index;
        end else begin
          check("req_index_stable", 64'(dcache_req.address_index), 64'(held_idx));
        end
        if (dcache_rsp.data_gnt) begin
          grants++;
          req_num++;
          req_active = 1'b0;
          stall_left = (req_num == stall_word) ? 5 : 0;
        end else if (stall_left > 0) begin
          stall_left--;
        end
      end else begin
        req_active = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on every BHT write and done pulse
  always @(posedge clk) begin
    logic [12:0] item;
    int          e;
    #6;
    if (bht_wr_valid) begin
      wr_seen++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL bht_unexpected_write: got row %0d col %0d entry %0h, expected no write",
                 bht_wr_row, bht_wr_col, bht_wr_entry);
      end else begin
        item = exp_q.pop_front();
        e    = int'(item[12:3]);
        check("bht_row",   64'(bht_wr_row),   64'(e / 2));
        check("bht_col",   64'(bht_wr_col),   64'(e % 2));
        check("bht_entry", 64'(bht_wr_entry), 64'(item[2:0]));
      end
    end
    if (done) begin
      done_cnt++;
      check("done_after_last_write", 64'(exp_q.size()), 64'd0);
    end
  end

  task automatic pulse_start(input logic [63:0] base);
    @(posedge clk); #1;
    restore_addr = base;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_full(input logic [63:0] base, input int m, input int sw);
    int t;
    set_run(base, m, sw, 1);
    push_exp(0, NR_ENTRIES, m);
    pulse_start(base);
    t = 0;
    while (done_cnt == 0 && t < 3000) begin
      @(posedge clk); #7;
      t++;
    end
    check("done_within_budget", 64'(done_cnt > 0), 64'd1);
    check("write_count", 64'(wr_seen), 64'(NR_ENTRIES));
    check("grant_count", 64'(grants), 64'(NR_WORDS));
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #6;
    check("busy_after_done", 64'(busy), 64'd0);
    check("done_pulse_count", 64'(done_cnt), 64'd1);
  endtask

  task automatic check_idle_after_abort(input string name);
    @(posedge clk); #1;
    abort = 1'b0;
    #5;
    check({name, "_busy_low"}, 64'(busy), 64'd0);
    repeat (3) @(posedge clk);
    #6;
    check({name, "_no_done"}, 64'(done_cnt), 64'd0);
    check({name, "_no_writes"}, 64'(wr_seen), 64'd0);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_dcache_req"}, 64'($countones(dcache_req)), 64'd0);
    check({name, "_wr_valid"}, 64'(bht_wr_valid), 64'd0);
    check({name, "_wr_fields"}, 64'({bht_wr_row, bht_wr_col, bht_wr_entry}), 64'd0);
    check({name, "_busy"}, 64'(busy), 64'd0);
    check({name, "_done"}, 64'(done), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    rst_n        = 1'b0;
    start        = 1'b0;
    abort        = 1'b0;
    restore_addr = '0;
    dcache_rsp   = '0;
    repeat (3) @(posedge clk);
    #6;
    check_outputs_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Full restore, immediate grant, e%8 pattern
    run_full(64'h0000_0000_8000_1000, 0, -1);
    // Grant withheld 5 cycles on word 3
    run_full(64'h0000_0000_1234_5000, 0, 3);
    // Final word all ones: only 16 writes from it
    run_full(64'h0000_0000_0000_2000, 1, -1);

    // Abort in REQ before grant
    set_run(64'h1000, 0, 0, 1);
    pulse_start(64'h1000);
    abort = 1'b1;
    #5;
    check("abort_req_drops_req", 64'(dcache_req.data_req), 64'd0);
    check_idle_after_abort("abort_req");

    // Abort in REQ with grant in the same cycle
    set_run(64'h2000, 0, -1, 1);
    pulse_start(64'h2000);
    abort = 1'b1;
    #5;
    check("abort_gnt_req_held", 64'(dcache_req.data_req), 64'd1);
    @(posedge clk); #1;
    abort = 1'b0;
    #5;
    check("abort_gnt_tag_kill", 64'({dcache_req.tag_valid, dcache_req.kill_req}), 64'b11);
    check_idle_after_abort("abort_gnt");

    // Abort in TAG
    set_run(64'h3000, 0, -1, 1);
    pulse_start(64'h3000);
    @(posedge clk); #1;
    abort = 1'b1;
    #5;
    check("abort_tag_kill", 64'({dcache_req.tag_valid, dcache_req.kill_req}), 64'b11);
    check_idle_after_abort("abort_tag");

    // Abort in WAIT: must drain the outstanding rvalid before going idle
    set_run(64'h4000, 0, -1, 4);
    pulse_start(64'h4000);
    @(posedge clk);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    t = 0;
    while (busy && t < 50) begin
      @(posedge clk); #6;
      t++;
    end
    check("abort_wait_idle_after_rvalid", 64'({busy, rv_fired}), 64'b01);
    repeat (2) @(posedge clk);
    #6;
    check("abort_wait_no_done", 64'(done_cnt), 64'd0);
    check("abort_wait_no_writes", 64'(wr_seen), 64'd0);

    // Abort in UNPACK after 5 writes
    set_run(64'h5000, 0, -1, 1);
    push_exp(0, 5, 0);
    pulse_start(64'h5000);
    t = 0;
    while (wr_seen < 5 && t < 50) begin
      @(posedge clk); #7;
      t++;
    end
    @(posedge clk); #1;
    abort = 1'b1;
    #5;
    check("abort_unpack_write_stops", 64'(bht_wr_valid), 64'd0);
    @(posedge clk); #1;
    abort = 1'b0;
    #5;
    check("abort_unpack_busy_low", 64'(busy), 64'd0);
    check("abort_unpack_writes", 64'(wr_seen), 64'd5);
    check("abort_unpack_no_done", 64'(done_cnt), 64'd0);

    // Start while busy is ignored; reset mid-UNPACK of word 1
    set_run(64'h0000_0000_4000_0000, 0, -1, 1);
    push_exp(0, EPW + 5, 0);
    pulse_start(64'h0000_0000_4000_0000);
    t = 0;
    while (wr_seen < 3 && t < 50) begin
      @(posedge clk); #7;
      t++;
    end
    pulse_start(64'h0000_0000_DEAD_0000);
    t = 0;
    while (wr_seen < EPW + 5 && t < 100) begin
      @(posedge clk); #7;
      t++;
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #5;
    check_outputs_zero("midrun_reset");
    check("midrun_writes", 64'(wr_seen), 64'(EPW + 5));
    check("midrun_grants", 64'(grants), 64'd2);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Restart from a base that wraps after word 0
    run_full(64'hFFFF_FFFF_FFFF_FFF8, 0, -1);
    check("wrap_word1_index", 64'(w1_index), 64'd0);
    check("wrap_word1_tag", 64'(w1_tag), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
